muldiv_seq: RTL

//  Multi-cycle sequencer for MULT/MULTU/DIV/DIVU.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_step.sv | 32 +++
 rtl/muldiv_seq.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [2:0] OP_MFHI  = 3'd6;
   localparam logic [2:0] OP_MFLO  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multi-cycle datapath: radix-2 shift-add (mode=0)
// or restoring subtract (mode=1) on a {upper, lower} accumulator.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic                 mode,
   input  logic [2*WIDTH-1:0]   acc,
   input  logic [WIDTH-1:0]     opb,
   output logic [2*WIDTH-1:0]   acc_next
);

   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   partial_s;
   logic [WIDTH-1:0] diff_s;
   logic             fits_s;

   // Next accumulator; for division the low half doubles as the quotient shift register
   always_comb begin
      sum_s     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
      partial_s = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      fits_s    = (partial_s >= {1'b0, opb});
      diff_s    = partial_s[WIDTH-1:0] - opb;
      if (!mode) begin
         acc_next = {sum_s, acc[WIDTH-1:1]};
      end else if (fits_s) begin
         acc_next = {diff_s, acc[WIDTH-2:0], 1'b1};
      end else begin
         acc_next = {partial_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; stalls the
// front of the pipeline while a result is pending.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_valid,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             flush,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_t             state_r;
   logic [2*WIDTH-1:0] acc_r;
   logic [WIDTH-1:0]   opb_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               div_r;
   logic               neg_q_r;
   logic               neg_r_r;

   logic [2*WIDTH-1:0] step_next_s;
   logic [2*WIDTH-1:0] prod_s;
   logic               accept_s;
   logic               signed_s;
   logic [WIDTH-1:0]   a_abs_s;
   logic [WIDTH-1:0]   b_abs_s;
   logic [WIDTH-1:0]   fix_hi_s;
   logic [WIDTH-1:0]   fix_lo_s;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? ({WIDTH{1'b0}} - v) : v;
   endfunction

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .mode     (div_r),
      .acc      (acc_r),
      .opb      (opb_r),
      .acc_next (step_next_s)
   );

   // Handshake with the pipeline and operand magnitudes for a new op
   always_comb begin
      stall    = op_valid & ~flush & busy;
      accept_s = op_valid & ~stall & ~flush;
      signed_s = (op == OP_MULT) || (op == OP_DIV);
      a_abs_s  = mag(rs_val, signed_s);
      b_abs_s  = mag(rt_val, signed_s);
   end

   // Sign fix-up; a divide-by-zero enters FIX with both flags clear
   always_comb begin
      prod_s = neg_q_r ? ({(2*WIDTH){1'b0}} - acc_r) : acc_r;
      if (div_r) begin
         fix_lo_s = neg_q_r ? ({WIDTH{1'b0}} - acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
         fix_hi_s = neg_r_r ? ({WIDTH{1'b0}} - acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
      end else begin
         fix_lo_s = prod_s[WIDTH-1:0];
         fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      end
   end

   // Move-from read port
   always_comb begin
      case (op)
         OP_MFHI: rd_data = hi;
         default: rd_data = lo;
      endcase
   end

   // Sequencer FSM and HI/LO registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         acc_r   <= {(2*WIDTH){1'b0}};
         opb_r   <= {WIDTH{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
         div_r   <= 1'b0;
         neg_q_r <= 1'b0;
         neg_r_r <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         hi      <= {WIDTH{1'b0}};
         lo      <= {WIDTH{1'b0}};
      end else begin
         done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  case (op)
                     OP_MULT, OP_MULTU: begin
                        state_r <= ST_MUL;
                        busy    <= 1'b1;
                        div_r   <= 1'b0;
                        cnt_r   <= {CNT_W{1'b0}};
                        acc_r   <= {{WIDTH{1'b0}}, b_abs_s};
                        opb_r   <= a_abs_s;
                        neg_q_r <= signed_s & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                        neg_r_r <= 1'b0;
                     end
                     OP_DIV, OP_DIVU: begin
                        busy    <= 1'b1;
                        div_r   <= 1'b1;
                        cnt_r   <= {CNT_W{1'b0}};
                        opb_r   <= b_abs_s;
                        if (rt_val == {WIDTH{1'b0}}) begin
                           state_r <= ST_FIX;
                           acc_r   <= {rs_val, {WIDTH{1'b1}}};
                           neg_q_r <= 1'b0;
                           neg_r_r <= 1'b0;
                        end else begin
                           state_r <= ST_DIV;
                           acc_r   <= {{WIDTH{1'b0}}, a_abs_s};
                           neg_q_r <= signed_s & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                           neg_r_r <= signed_s & rs_val[WIDTH-1];
                        end
                     end
                     OP_MTHI: hi <= rs_val;
                     OP_MTLO: lo <= rs_val;
                     default: ;
                  endcase
               end
            end
            ST_MUL, ST_DIV: begin
               if (flush) begin
                  state_r <= ST_IDLE;
                  busy    <= 1'b0;
               end else begin
                  acc_r <= step_next_s;
                  cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                  if (cnt_r == CNT_W'(WIDTH-1)) begin
                     state_r <= ST_FIX;
                  end
               end
            end
            ST_FIX: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
               if (!flush) begin
                  hi   <= fix_hi_s;
                  lo   <= fix_lo_s;
                  done <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
